// File: rtl/pipe_share_ctrl_pkg.sv
// Shared definitions for the two-requester pipelined datapath controller:
// datapath latency and the {valid, tag} issue-tracking entry.
package pipe_share_ctrl_pkg;

    localparam int LAT = 3;

    localparam logic TAG_REQ0 = 1'b0;
    localparam logic TAG_REQ1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic tag;
    } trk_t;

endpackage

// File: rtl/pipe_share_ctrl_ex.sv
// Shared datapath: F = ((A+B)+(C-D))*D mod 2^N, three register stages,
// free-running (no enable, no reset on data).
module pipe_ex #(
    parameter int N = 10
) (
    output logic [N-1:0] F,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic         clk
);

    logic [N-1:0] r_ab_p0;
    logic [N-1:0] r_cd_p0;
    logic [N-1:0] r_d_p0;
    logic [N-1:0] r_s_p1;
    logic [N-1:0] r_d_p1;
    logic [N-1:0] r_f_p2;

    // p0: partial sums
    always_ff @(posedge clk) begin
        r_ab_p0 <= A + B;
        r_cd_p0 <= C - D;
        r_d_p0  <= D;
    end

    // p1: full sum
    always_ff @(posedge clk) begin
        r_s_p1 <= r_ab_p0 + r_cd_p0;
        r_d_p1 <= r_d_p0;
    end

    // p2: product, truncated to N bits
    always_ff @(posedge clk) begin
        r_f_p2 <= r_s_p1 * r_d_p1;
    end

    assign F = r_f_p2;

endmodule

// File: rtl/pipe_share_ctrl.sv
// Round-robin arbiter sharing one pipe_ex between two requesters; a tag
// shift register routes each result back to the requester that issued it.
module pipe_share_ctrl
    import pipe_share_ctrl_pkg::*;
#(
    parameter int N   = 10,
    parameter int LAT = pipe_share_ctrl_pkg::LAT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req0_c,
    input  logic [N-1:0] req0_d,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [N-1:0] req1_c,
    input  logic [N-1:0] req1_d,
    output logic         res0_valid,
    output logic [N-1:0] res0_f,
    output logic         res1_valid,
    output logic [N-1:0] res1_f,
    output logic [1:0]   inflight
);

    logic         r_rr;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_xfer;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_c;
    logic [N-1:0] w_d;
    logic [N-1:0] w_f;
    trk_t         r_trk [LAT];
    logic         w_last0;
    logic         w_last1;
    logic         r_res0_valid;
    logic         r_res1_valid;
    logic [N-1:0] r_res0_f;
    logic [N-1:0] r_res1_f;
    logic [1:0]   w_inflight;

    // r_rr breaks ties only; a lone requester always wins
    assign w_gnt0 = !rst && req0_valid && (!req1_valid || (r_rr == TAG_REQ0));
    assign w_gnt1 = !rst && req1_valid && (!req0_valid || (r_rr == TAG_REQ1));
    assign w_xfer = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        w_d = '0;
        if (w_gnt0) begin
            w_a = req0_a;
            w_b = req0_b;
            w_c = req0_c;
            w_d = req0_d;
        end else if (w_gnt1) begin
            w_a = req1_a;
            w_b = req1_b;
            w_c = req1_c;
            w_d = req1_d;
        end
    end

    pipe_ex #(.N(N)) u_ex (
        .F   (w_f),
        .A   (w_a),
        .B   (w_b),
        .C   (w_c),
        .D   (w_d),
        .clk (clk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= TAG_REQ0;
        end else if (w_xfer) begin
            r_rr <= w_gnt1 ? TAG_REQ0 : TAG_REQ1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_trk[i] <= '0;
            end
        end else begin
            r_trk[0] <= '{valid: w_xfer, tag: w_gnt1};
            for (int i = 1; i < LAT; i++) begin
                r_trk[i] <= r_trk[i-1];
            end
        end
    end

    assign w_last0 = r_trk[LAT-1].valid && (r_trk[LAT-1].tag == TAG_REQ0);
    assign w_last1 = r_trk[LAT-1].valid && (r_trk[LAT-1].tag == TAG_REQ1);

    // Result register: aligns the tag with pipe_ex output and zeroes idle data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res0_valid <= 1'b0;
            r_res1_valid <= 1'b0;
            r_res0_f     <= '0;
            r_res1_f     <= '0;
        end else begin
            r_res0_valid <= w_last0;
            r_res1_valid <= w_last1;
            r_res0_f     <= w_last0 ? w_f : '0;
            r_res1_f     <= w_last1 ? w_f : '0;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + {1'b0, r_trk[i].valid};
        end
    end

    assign res0_valid = r_res0_valid;
    assign res1_valid = r_res1_valid;
    assign res0_f     = r_res0_f;
    assign res1_f     = r_res1_f;
    assign inflight   = w_inflight;

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Bench for pipe_share_ctrl: directed scenarios then random traffic, checked
// against an issue-log model (result due three edges after issue).
module tb_pipe_share_ctrl;

    localparam int N   = 10;
    localparam int MAX = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req0_c, req0_d;
    logic [N-1:0] req1_a, req1_b, req1_c, req1_d;
    logic         res0_valid, res1_valid;
    logic [N-1:0] res0_f, res1_f;
    logic [1:0]   inflight;

    int checks = 0;
    int failures = 0;

    // model state: per-edge issue log and tie-break pointer
    bit           iss_v   [MAX];
    bit           iss_tag [MAX];
    logic [N-1:0] iss_f   [MAX];
    int           e;
    bit           m_rr;

    pipe_share_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req0_d     (req0_d),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .req1_d     (req1_d),
        .res0_valid (res0_valid),
        .res0_f     (res0_f),
        .res1_valid (res1_valid),
        .res1_f     (res1_f),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] fref(input int a, input int b, input int c, input int d);
        longint t;
        t = ((longint'(a) + b) + (longint'(c) - d)) * d;
        return N'(t & ((longint'(1) << N) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev0, ev1;
        int n;
        ev0 = iss_v[e-3] && !iss_tag[e-3];
        ev1 = iss_v[e-3] && iss_tag[e-3];
        n = int'(iss_v[e]) + int'(iss_v[e-1]) + int'(iss_v[e-2]);
        chk("res0_valid", 32'(res0_valid), 32'(ev0));
        chk("res0_f",     32'(res0_f),     ev0 ? 32'(iss_f[e-3]) : 32'd0);
        chk("res1_valid", 32'(res1_valid), 32'(ev1));
        chk("res1_f",     32'(res1_f),     ev1 ? 32'(iss_f[e-3]) : 32'd0);
        chk("inflight",   32'(inflight),   32'(n));
    endtask

    // one clock: drive, check readies, take the edge, check results
    task automatic cycle(input bit v0, input int a0, input int b0, input int c0, input int d0,
                         input bit v1, input int a1, input int b1, input int c1, input int d1);
        bit g0, g1;
        req0_valid = v0; req0_a = N'(a0); req0_b = N'(b0); req0_c = N'(c0); req0_d = N'(d0);
        req1_valid = v1; req1_a = N'(a1); req1_b = N'(b1); req1_c = N'(c1); req1_d = N'(d1);
        #1;
        g0 = v0 && (!v1 || m_rr == 1'b0);
        g1 = v1 && !g0;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        @(posedge clk);
        e++;
        iss_v[e]   = g0 || g1;
        iss_tag[e] = g1;
        iss_f[e]   = g0 ? fref(a0, b0, c0, d0) : fref(a1, b1, c1, d1);
        if (g0 || g1) m_rr = g0;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_res0_valid", 32'(res0_valid), 32'd0);
        chk("rst_res1_valid", 32'(res1_valid), 32'd0);
        chk("rst_res0_f", 32'(res0_f), 32'd0);
        chk("rst_res1_f", 32'(res1_f), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        for (int i = e - 4; i <= e + 1; i++) iss_v[i] = 1'b0;
        m_rr = 1'b0;
        @(posedge clk);
        e++;
        #1;
        check_outputs();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        e = 8;
        m_rr = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_c = '0; req0_d = '0;
        req1_a = '0; req1_b = '0; req1_c = '0; req1_d = '0;
        #1;
        do_reset();

        // solo requester 0
        cycle(1, 10, 12, 6, 3, 0, 0, 0, 0, 0);
        idle(2);
        chk("solo_res_pending", 32'(res0_valid), 32'd0);
        idle(1);
        chk("solo_res0_f", 32'(res0_f), 32'd75);
        idle(2);

        // contention straight after reset: grants 0,1,0,1
        do_reset();
        cycle(1, 10, 10, 5, 3, 1, 15, 10, 8, 2);
        cycle(1, 20, 11, 1, 4, 1, 15, 10, 8, 2);
        cycle(1, 20, 11, 1, 4, 1, 8, 15, 5, 0);
        cycle(1, 7, 7, 7, 7, 1, 8, 15, 5, 0);
        chk("cont_order0", 32'(res0_f), 32'd66);
        idle(1);
        chk("cont_order1", 32'(res1_f), 32'd62);
        idle(4);

        // back-to-back from requester 1
        cycle(0, 0, 0, 0, 0, 1, 10, 10, 30, 1);
        cycle(0, 0, 0, 0, 0, 1, 30, 1, 2, 4);
        cycle(0, 0, 0, 0, 0, 1, 10, 12, 6, 3);
        chk("b2b_inflight", 32'(inflight), 32'd3);
        idle(5);

        // modulo wrap
        cycle(1, 1023, 1, 0, 2, 0, 0, 0, 0, 0);
        idle(4);

        // reset with two operations in flight
        cycle(1, 5, 6, 7, 2, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 9, 9, 9, 3);
        chk("mid_inflight", 32'(inflight), 32'd2);
        do_reset();
        idle(5);
        cycle(1, 1, 2, 3, 1, 1, 4, 5, 6, 2);
        chk("post_rst_winner", 32'(iss_tag[e]), 32'd0);
        idle(4);

        // idle gaps: pointer remembers the last winner
        cycle(1, 3, 3, 3, 3, 0, 0, 0, 0, 0);
        idle(2);
        cycle(1, 2, 2, 2, 2, 1, 6, 6, 6, 6);
        chk("gap_winner", 32'(iss_tag[e]), 32'd1);
        idle(4);

        // random traffic with operands changing freely
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
